// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for the ID-stage branch sequencer: branch opcodes, REGIMM sub-ops, FSM states.
// Build option: BRANCH_DELAY_SLOT_EN (see branch_resolve_ctrl.sv).
package branch_resolve_ctrl_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } br_state_e;

    function automatic logic is_link_op(input logic [5:0] op, input logic [4:0] rt);
        return (op == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode/hazard/PC-mux bundle around the branch sequencer; master = pipeline side, slave = sequencer.
// flush_d only exists when BRANCH_DELAY_SLOT_EN is undefined.
interface branch_resolve_ctrl_if;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_regwrite;
    logic       ex_memtoreg;
    logic [4:0] ex_writereg;
    logic       mem_memtoreg;
    logic [4:0] mem_writereg;
    logic       cmp_result;
    logic       hold_in;
    logic       flush_in;

    logic       stall_f;
    logic       stall_d;
    logic       flush_e;
    logic       pc_src_branch;
    logic       link_we;
    logic       busy;
`ifndef BRANCH_DELAY_SLOT_EN
    logic       flush_d;
`endif

    modport master (
        output id_valid, id_opcode, id_rs, id_rt,
        output ex_regwrite, ex_memtoreg, ex_writereg, mem_memtoreg, mem_writereg,
        output cmp_result, hold_in, flush_in,
        input  stall_f, stall_d, flush_e, pc_src_branch, link_we, busy
`ifndef BRANCH_DELAY_SLOT_EN
        , input flush_d
`endif
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt,
        input  ex_regwrite, ex_memtoreg, ex_writereg, mem_memtoreg, mem_writereg,
        input  cmp_result, hold_in, flush_in,
        output stall_f, stall_d, flush_e, pc_src_branch, link_we, busy
`ifndef BRANCH_DELAY_SLOT_EN
        , output flush_d
`endif
    );

endinterface

// File: rtl/branch_resolve_ctrl_hazard.sv
// Combinational branch classification and stall-depth computation for the ID-stage branch.
// need is the worst case over the branch's source operands; $0 never creates a hazard.
module branch_hazard_detect
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int ALU_WAIT  = 1,
    parameter int LOAD_WAIT = 2,
    parameter int CNT_W     = 2
) (
    input  logic [5:0]       id_opcode_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_regwrite_i,
    input  logic             ex_memtoreg_i,
    input  logic [4:0]       ex_writereg_i,
    input  logic             mem_memtoreg_i,
    input  logic [4:0]       mem_writereg_i,
    output logic             is_br_o,
    output logic             is_link_o,
    output logic [CNT_W-1:0] need_o
);

    logic                  uses_rt;
    logic                  is_regimm_br;
    logic [1:0][CNT_W-1:0] src_need;

    assign uses_rt      = (id_opcode_i == OP_BEQ) || (id_opcode_i == OP_BNE);
    assign is_regimm_br = (id_opcode_i == OP_REGIMM) &&
                          ((id_rt_i == RT_BLTZ)   || (id_rt_i == RT_BGEZ) ||
                           (id_rt_i == RT_BLTZAL) || (id_rt_i == RT_BGEZAL));
    assign is_br_o      = uses_rt || (id_opcode_i == OP_BLEZ) || (id_opcode_i == OP_BGTZ) ||
                          is_regimm_br;
    assign is_link_o    = is_link_op(id_opcode_i, id_rt_i);

    // Operand 0 is rs (always read), operand 1 is rt (read only by BEQ/BNE).
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [4:0] src;
        logic       src_en;
        logic       hit_ex;
        logic       hit_mem;

        assign src     = (gi == 0) ? id_rs_i : id_rt_i;
        assign src_en  = (gi == 0) ? 1'b1 : uses_rt;
        assign hit_ex  = src_en && (src != REG_ZERO) && (ex_writereg_i == src);
        assign hit_mem = src_en && (src != REG_ZERO) && (mem_writereg_i == src);

        assign src_need[gi] = (hit_ex && ex_memtoreg_i)   ? CNT_W'(LOAD_WAIT) :
                              (hit_ex && ex_regwrite_i)   ? CNT_W'(ALU_WAIT)  :
                              (hit_mem && mem_memtoreg_i) ? CNT_W'(1)         :
                                                            '0;
    end

    assign need_o = (src_need[0] > src_need[1]) ? src_need[0] : src_need[1];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: stalls IF/ID and bubbles EX until operands are ready, then resolves once.
// BRANCH_DELAY_SLOT_EN defined: no flush_d; undefined: taken resolve squashes IF via flush_d.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int ALU_WAIT  = 1,
    parameter int LOAD_WAIT = 2,
    parameter int CNT_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_ctrl_if.slave  bus
);

    br_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             link_q;
    logic             busy_q;

    logic             is_br;
    logic             is_link;
    logic [CNT_W-1:0] need;
    logic             start;

    logic             stall_c;
    logic             flush_e_c;
    logic             pc_src_c;
    logic             link_c;

    branch_hazard_detect #(
        .ALU_WAIT  (ALU_WAIT),
        .LOAD_WAIT (LOAD_WAIT),
        .CNT_W     (CNT_W)
    ) u_hazard (
        .id_opcode_i    (bus.id_opcode),
        .id_rs_i        (bus.id_rs),
        .id_rt_i        (bus.id_rt),
        .ex_regwrite_i  (bus.ex_regwrite),
        .ex_memtoreg_i  (bus.ex_memtoreg),
        .ex_writereg_i  (bus.ex_writereg),
        .mem_memtoreg_i (bus.mem_memtoreg),
        .mem_writereg_i (bus.mem_writereg),
        .is_br_o        (is_br),
        .is_link_o      (is_link),
        .need_o         (need)
    );

    assign start = bus.id_valid && is_br;
    assign cnt_d = cnt_q - CNT_W'(1);

    // The detection cycle is the first stall cycle, so a depth-N hazard stalls exactly N cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            link_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (bus.flush_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (!bus.hold_in) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && (need != '0)) begin
                        cnt_q   <= need;
                        link_q  <= is_link;
                        busy_q  <= 1'b1;
                        state_q <= (need == CNT_W'(1)) ? ST_RESOLVE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == CNT_W'(1)) begin
                        state_q <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are held low while reset is asserted so downstream sees no stray stall or redirect.
    always_comb begin
        stall_c   = 1'b0;
        flush_e_c = 1'b0;
        pc_src_c  = 1'b0;
        link_c    = 1'b0;
        if (!rst) begin
            stall_c = 1'b0;
        end else if (bus.flush_in) begin
            flush_e_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !bus.hold_in) begin
                        if (need == '0) begin
                            pc_src_c = bus.cmp_result;
                            link_c   = is_link;
                        end else begin
                            stall_c   = 1'b1;
                            flush_e_c = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    stall_c   = 1'b1;
                    flush_e_c = 1'b1;
                end
                ST_RESOLVE: begin
                    if (!bus.hold_in) begin
                        pc_src_c = bus.cmp_result;
                        link_c   = link_q;
                    end
                end
                default: begin
                    stall_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.stall_f       = stall_c;
    assign bus.stall_d       = stall_c;
    assign bus.flush_e       = flush_e_c;
    assign bus.pc_src_branch = pc_src_c;
    assign bus.link_we       = link_c;
    assign bus.busy          = busy_q;
`ifndef BRANCH_DELAY_SLOT_EN
    assign bus.flush_d       = pc_src_c;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios followed by random traffic,
// all cycles checked against a stall-countdown reference model.
module tb_branch_resolve_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_ctrl_if bus ();

    branch_resolve_ctrl #(
        .ALU_WAIT  (1),
        .LOAD_WAIT (2),
        .CNT_W     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: stall cycles still owed, a pending resolve, and the pending link flag.
    int m_left = 0;
    bit m_res  = 1'b0;
    bit m_link = 1'b0;

    logic o_sf, o_pc, o_lk, o_fd;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_is_br(input bit [5:0] op, input bit [4:0] rt);
        if (op >= 6'd4 && op <= 6'd7) return 1'b1;
        if (op == 6'd1 && (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_is_link(input bit [5:0] op, input bit [4:0] rt);
        return (op == 6'd1) && (rt == 5'd16 || rt == 5'd17);
    endfunction

    function automatic int ref_need(input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                                    input bit exw, input bit exl, input bit [4:0] exr,
                                    input bit meml, input bit [4:0] memr);
        int worst;
        bit [4:0] srcs [$];
        worst = 0;
        srcs.push_back(rs);
        if (op == 6'd4 || op == 6'd5) srcs.push_back(rt);
        foreach (srcs[k]) begin
            int w;
            w = 0;
            if (srcs[k] != 5'd0) begin
                if (exl && exr == srcs[k])         w = 2;
                else if (exw && exr == srcs[k])    w = 1;
                else if (meml && memr == srcs[k])  w = 1;
            end
            if (w > worst) worst = w;
        end
        return worst;
    endfunction

    task automatic drive(input bit v, input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                         input bit exw, input bit exl, input bit [4:0] exr,
                         input bit meml, input bit [4:0] memr,
                         input bit cmp, input bit hold, input bit flush);
        bus.id_valid     = v;
        bus.id_opcode    = op;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.ex_regwrite  = exw;
        bus.ex_memtoreg  = exl;
        bus.ex_writereg  = exr;
        bus.mem_memtoreg = meml;
        bus.mem_writereg = memr;
        bus.cmp_result   = cmp;
        bus.hold_in      = hold;
        bus.flush_in     = flush;
    endtask

    // Called at posedge+1 with inputs already driven; checks at the falling edge, returns at next posedge+1.
    task automatic cycle(input string tag);
        bit e_st, e_fe, e_pc, e_lk, e_busy, br, lk;
        int need;
        #4;
        e_st = 0; e_fe = 0; e_pc = 0; e_lk = 0;
        e_busy = (m_left > 0) || m_res;
        br   = ref_is_br(bus.id_opcode, bus.id_rt);
        lk   = ref_is_link(bus.id_opcode, bus.id_rt);
        need = ref_need(bus.id_opcode, bus.id_rs, bus.id_rt, bus.ex_regwrite, bus.ex_memtoreg,
                        bus.ex_writereg, bus.mem_memtoreg, bus.mem_writereg);
        if (bus.flush_in) begin
            e_fe = 1; m_left = 0; m_res = 0;
        end else if (bus.hold_in) begin
            if (m_left > 0) begin e_st = 1; e_fe = 1; end
        end else if (m_left > 0) begin
            e_st = 1; e_fe = 1;
            m_left--;
            if (m_left == 0) m_res = 1;
        end else if (m_res) begin
            e_pc = bus.cmp_result; e_lk = m_link; m_res = 0;
        end else if (bus.id_valid && br) begin
            if (need == 0) begin
                e_pc = bus.cmp_result; e_lk = lk;
            end else begin
                e_st = 1; e_fe = 1;
                m_left = need - 1; m_res = (m_left == 0); m_link = lk;
            end
        end
        chk({tag, ".stall_f"}, bus.stall_f, e_st);
        chk({tag, ".stall_d"}, bus.stall_d, e_st);
        chk({tag, ".flush_e"}, bus.flush_e, e_fe);
        chk({tag, ".pc_src"},  bus.pc_src_branch, e_pc);
        chk({tag, ".link_we"}, bus.link_we, e_lk);
        chk({tag, ".busy"},    bus.busy, e_busy);
`ifndef BRANCH_DELAY_SLOT_EN
        chk({tag, ".flush_d"}, bus.flush_d, e_pc);
        o_fd = bus.flush_d;
`else
        o_fd = 1'b0;
`endif
        o_sf = bus.stall_f;
        o_pc = bus.pc_src_branch;
        o_lk = bus.link_we;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag);
        drive(0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        cycle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stalls;
        int res_at;
        int pcs;
        bit [5:0] ops [9];
        bit [4:0] rts [6];
        ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd0, 6'd35, 6'd8};
        rts = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd16, 5'd17};

        // Reset state: even with a hazarding branch presented, every output stays low.
        drive(1, 6'd5, 5'd3, 5'd0, 1, 1, 5'd3, 0, 5'd0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall_f", bus.stall_f, 1'b0);
        chk("reset.flush_e", bus.flush_e, 1'b0);
        chk("reset.pc_src",  bus.pc_src_branch, 1'b0);
        chk("reset.busy",    bus.busy, 1'b0);
        drive(0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted mid-WAIT clears everything immediately.
        drive(1, 6'd5, 5'd3, 5'd0, 1, 1, 5'd3, 0, 5'd0, 1, 0, 0);
        cycle("rstwait.detect");
        #1;
        chk("rstwait.in_wait", bus.stall_f, 1'b1);
        rst = 1'b0;
        #1;
        chk("rstwait.stall_f", bus.stall_f, 1'b0);
        chk("rstwait.stall_d", bus.stall_d, 1'b0);
        chk("rstwait.flush_e", bus.flush_e, 1'b0);
        chk("rstwait.pc_src",  bus.pc_src_branch, 1'b0);
        chk("rstwait.link_we", bus.link_we, 1'b0);
        chk("rstwait.busy",    bus.busy, 1'b0);
        m_left = 0; m_res = 0;
        drive(0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle("rstwait.after");

        // BEQ $1,$2 without hazard resolves in the same cycle.
        drive(1, 6'd4, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
        cycle("beq");
        chk("beq.taken_now", o_pc, 1'b1);
        chk("beq.no_stall",  o_sf, 1'b0);
        idle_cycle("beq.idle");

        // lw $3 in EX, BNE $3,$0: two stall cycles, resolve on the third.
        drive(1, 6'd5, 5'd3, 5'd0, 1, 1, 5'd3, 0, 5'd0, 1, 0, 0);
        stalls = 0; res_at = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle($sformatf("lwbne%0d", i));
            if (o_pc) begin res_at = i; break; end
            if (o_sf) stalls++;
        end
        chk_int("lwbne.stalls", stalls, 2);
        chk_int("lwbne.resolve_cycle", res_at, 3);
        idle_cycle("lwbne.idle");

        // add $5 in EX, BGEZAL $5 not taken: one stall, then link write without redirect.
        drive(1, 6'd1, 5'd5, 5'd17, 1, 0, 5'd5, 0, 5'd0, 0, 0, 0);
        stalls = 0; res_at = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle($sformatf("bgezal%0d", i));
            if (o_lk) begin res_at = i; break; end
            if (o_sf) stalls++;
        end
        chk_int("bgezal.stalls", stalls, 1);
        chk_int("bgezal.resolve_cycle", res_at, 2);
        chk("bgezal.not_taken", o_pc, 1'b0);
        idle_cycle("bgezal.idle");

        // hold_in for three WAIT cycles delays the resolve by exactly three cycles.
        drive(1, 6'd5, 5'd3, 5'd0, 1, 1, 5'd3, 0, 5'd0, 1, 0, 0);
        stalls = 0; res_at = 0;
        for (int i = 1; i <= 10; i++) begin
            bus.hold_in = (i >= 2 && i <= 4);
            cycle($sformatf("hold%0d", i));
            if (o_pc) begin res_at = i; break; end
            if (o_sf) stalls++;
        end
        chk_int("hold.resolve_cycle", res_at, 6);
        chk_int("hold.stalls", stalls, 5);
        idle_cycle("hold.idle");

        // flush_in during WAIT abandons the branch with no redirect.
        drive(1, 6'd5, 5'd3, 5'd0, 1, 1, 5'd3, 0, 5'd0, 1, 0, 0);
        cycle("flush.detect");
        bus.flush_in = 1'b1;
        cycle("flush.flush");
        pcs = 0;
        for (int i = 0; i < 3; i++) begin
            idle_cycle($sformatf("flush.after%0d", i));
            pcs += int'(o_pc);
        end
        chk_int("flush.no_redirect", pcs, 0);

        // BGTZ taken / not taken without hazard; taken one squashes IF when no delay slot.
        drive(1, 6'd7, 5'd4, 5'd0, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
        cycle("bgtz_t");
`ifndef BRANCH_DELAY_SLOT_EN
        chk("bgtz_t.flush_d", o_fd, 1'b1);
`endif
        drive(1, 6'd7, 5'd4, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        cycle("bgtz_n");
        chk("bgtz_n.flush_d", o_fd, 1'b0);
        idle_cycle("bgtz.idle");

        // Load in MEM costs one stall; a producer writing $0 never hazards.
        drive(1, 6'd7, 5'd4, 5'd0, 0, 0, 5'd0, 1, 5'd4, 1, 0, 0);
        cycle("memld1");
        chk("memld1.stall", o_sf, 1'b1);
        cycle("memld2");
        chk("memld2.resolve", o_pc, 1'b1);
        drive(1, 6'd6, 5'd0, 5'd0, 1, 1, 5'd0, 1, 5'd0, 1, 0, 0);
        cycle("reg0");
        chk("reg0.no_stall", o_sf, 1'b0);
        idle_cycle("reg0.idle");

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 9) != 0), ops[$urandom_range(0, 8)],
                  5'($urandom_range(0, 3)), rts[$urandom_range(0, 5)],
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 6) == 0),
                  1'($urandom_range(0, 19) == 0));
            cycle($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
